uev_axis_out: RTL and testbench
===============================

UEV_AXIS_OUT -- requirements
Module: uev_axis_out

Interface
REQ-001 SHALL have parameter DEPTH, default 64, FIFO depth in words (power of 2, 16..512).
REQ-002 SHALL have parameter START_THRESH, default 8, max fill at which a new event may start.
REQ-003 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port clk_ce_i, input, 1, half-rate data phase from the readout state machine.
REQ-006 SHALL have port ev_tdata_i, input, 8, event word (header or URAM data).
REQ-007 SHALL have port ev_valid_i, input, 1, word valid, qualified by clk_ce_i.
REQ-008 SHALL have port ev_last_i, input, 1, marks the final word of an event, qualified like ev_valid_i.
REQ-009 SHALL have ports m_axis_tdata (output, 8), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1); together these form the AXI4-Stream master.
REQ-010 SHALL have port start_ok_o, output, 1, permission to begin a new event; gates data_available upstream.
REQ-011 SHALL have port overflow_o, output, 1, sticky overflow flag.
REQ-012 SHALL have port clr_err_i, input, 1, clears sticky flags.
REQ-013 SHALL have port event_count_o, output, 16, count of completed output events.

Function
REQ-014 SHALL push {ev_last_i, ev_tdata_i} into the FIFO when ev_valid_i && clk_ce_i && (!full || pop).
REQ-015 SHALL drop the word and set overflow_o when a push is requested while full and no pop occurs in the same cycle.
REQ-016 SHALL drive m_axis_tvalid = !empty, with m_axis_tdata and m_axis_tlast taken from the head entry; a pop occurs on m_axis_tvalid && m_axis_tready.
REQ-017 SHALL give a push-to-tvalid latency of exactly 1 clk when the FIFO is empty.
REQ-018 SHALL keep tdata and tlast stable while tvalid && !tready.
REQ-019 SHALL use read/write pointers of log2(DEPTH)+1 bits, with the MSB as the wrap bit: full = MSB differs and lower bits equal; empty = pointers equal; both wrap modulo 2*DEPTH.
REQ-020 SHALL keep fill count = wr_ptr - rd_ptr, (log2(DEPTH)+1) bits; fill SHALL be unchanged on a simultaneous push and pop.
REQ-021 SHALL register start_ok_o = (fill <= START_THRESH) && !in_event, 1 clk latency.
REQ-022 SHALL set in_event on the first accepted push and clear it on the accepted push carrying ev_last_i.
REQ-023 SHALL increment event_count_o on each tlast handshake and wrap 0xFFFF->0.
REQ-024 SHALL have clr_err_i clear overflow_o the next clk; a simultaneous overflow event SHALL win (flag stays set).

Reset
REQ-025 SHALL, on rst_i, set both pointers to 0, empty the FIFO, and set m_axis_tvalid=0, start_ok_o=0, overflow_o=0, event_count_o=0 and in_event=0; start_ok_o SHALL be 1 on the 2nd clk after rst_i falls.
REQ-026 SHALL discard a partially stored event on reset mid-event; the first post-reset word SHALL begin a new event.

Configuration
REQ-027 SHALL compile in, when macro UEV_AXIS_LENCHECK_EN is defined, a word counter per input event compared against EVENT_WORDS from the package at ev_last_i; on mismatch it SHALL set sticky length_err_o (output, 1, cleared by clr_err_i); the counter saturates at 0xFFFF.
REQ-028 SHALL, without the macro, tie length_err_o to 0 and omit the counter.

Structure
REQ-029 SHALL keep constants EVENT_WORDS (4 header + 8*1536 data) and HEADER_WORDS=4 in package uram_event_pkg.
REQ-030 SHALL place FIFO storage and pointers in sub-module uev_axis_fifo (inferred distributed/block RAM, registered output); flags, start gating and counters SHALL live in the top.

Verification
REQ-031 SHALL verify: push 10 words (last on the 10th) with tready=1 -> 10 beats out, tlast only on beat 10, event_count_o=1.
REQ-032 SHALL verify: tready=0 and 64 pushes, then a 65th push -> overflow_o=1, fill=64, and the 65th word is absent from the output.
REQ-033 SHALL verify: full FIFO, tready=1 and push in the same cycle -> word accepted, overflow_o stays 0, fill stays 64.
REQ-034 SHALL verify: fill=9 -> start_ok_o=0; drain to 8 -> start_ok_o=1 one clk later; mid-event -> start_ok_o=0.
REQ-035 SHALL verify: rst_i pulsed after 5 words of an event -> tvalid=0 the next clk; a new 3-word event then yields exactly 3 beats.
REQ-036 SHALL verify, with UEV_AXIS_LENCHECK_EN defined: an event of EVENT_WORDS-1 words -> length_err_o=1; clr_err_i -> 0.

Source files
------------

// File: rtl/uram_event_pkg.sv
// Event framing constants shared by the URAM readout path and its AXI4-Stream output stage.
package uram_event_pkg;

  localparam int HEADER_WORDS = 4;
  localparam int DATA_WORDS   = 8 * 1536;
  localparam int EVENT_WORDS  = HEADER_WORDS + DATA_WORDS;

  // One FIFO entry: the event word plus its end-of-event marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

endpackage

// File: rtl/uev_axis_out_if.sv
// Byte-wide AXI4-Stream link. Handshake: a beat transfers on the clk edge where tvalid && tready;
// once tvalid is high, tdata/tlast hold until that transfer, and tvalid never depends on tready.
interface uev_axis_out_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/uev_axis_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage is written on clk and read from the registered array.
module uev_axis_fifo
  import uram_event_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  fifo_word_t wr_data_i,
  input  logic       pop_i,
  output fifo_word_t rd_data_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [AW:0] fill_o
);

  fifo_word_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A push into a full FIFO alongside a pop reuses the slot being read out this cycle.
  assign rd_data_o = mem[rd_ptr[AW-1:0]];
  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill_o    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uev_axis_out.sv
// Event word FIFO to AXI4-Stream master with start gating, sticky overflow and event counting.
// Optional input event length check compiled in with `define UEV_AXIS_LENCHECK_EN.
module uev_axis_out
  import uram_event_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int START_THRESH = 8,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_ce_i,
  input  logic [7:0]            ev_tdata_i,
  input  logic                  ev_valid_i,
  input  logic                  ev_last_i,
  uev_axis_out_if.master        m_axis,
  output logic                  start_ok_o,
  output logic                  overflow_o,
  input  logic                  clr_err_i,
  output logic [15:0]           event_count_o,
  output logic                  length_err_o,
  output logic [AW:0]           dbg_fill_o,
  output logic                  dbg_in_event_o
);

  localparam int          PW       = AW + 1;
  localparam logic [AW:0] THRESH_W = PW'(START_THRESH);

  fifo_word_t  head;
  fifo_word_t  wr_word;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push_acc;
  logic [AW:0] fill;
  logic        in_event;

  assign pop      = !empty && m_axis.tready;
  assign push_req = ev_valid_i && clk_ce_i;
  assign push_acc = push_req && (!full || pop);
  assign wr_word  = '{last: ev_last_i, data: ev_tdata_i};

  uev_axis_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push_acc),
    .wr_data_i (wr_word),
    .pop_i     (pop),
    .rd_data_o (head),
    .empty_o   (empty),
    .full_o    (full),
    .fill_o    (fill)
  );

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = head.data;
  assign m_axis.tlast  = head.last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_event      <= 1'b0;
      start_ok_o    <= 1'b0;
      overflow_o    <= 1'b0;
      event_count_o <= '0;
    end else begin
      if (push_acc) in_event <= !ev_last_i;
      start_ok_o <= (fill <= THRESH_W) && !in_event;
      // A fresh overflow outranks a clear arriving in the same cycle.
      if (push_req && full && !pop) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (pop && head.last) event_count_o <= event_count_o + 16'd1;
    end
  end

`ifdef UEV_AXIS_LENCHECK_EN
  localparam logic [15:0] EVENT_WORDS_W = 16'(EVENT_WORDS);

  logic [15:0] word_cnt;
  logic [15:0] word_cnt_nxt;
  logic        len_err_q;

  // Count includes the current word and saturates so oversize events still flag.
  always_comb begin
    word_cnt_nxt = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt  <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (push_req) word_cnt <= ev_last_i ? 16'd0 : word_cnt_nxt;
      if (push_req && ev_last_i && (word_cnt_nxt != EVENT_WORDS_W)) begin
        len_err_q <= 1'b1;
      end else if (clr_err_i) begin
        len_err_q <= 1'b0;
      end
    end
  end

  assign length_err_o = len_err_q;
`else
  assign length_err_o = 1'b0;
`endif

  assign dbg_fill_o     = fill;
  assign dbg_in_event_o = in_event;

endmodule

// File: tb/tb_uev_axis_out.sv
// Bench for uev_axis_out: queue-based reference model compared every cycle, plus directed literal checks.
module tb_uev_axis_out;
  import uram_event_pkg::*;

  localparam int DEPTH  = 64;
  localparam int THRESH = 8;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data = 8'h00;

  logic        start_ok;
  logic        ovf;
  logic        len_err;
  logic        in_ev_dbg;
  logic [15:0] ev_cnt;
  logic [6:0]  fill;

  uev_axis_out_if axis ();

  always #5 clk = ~clk;

  uev_axis_out #(
    .DEPTH        (DEPTH),
    .START_THRESH (THRESH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_ce_i       (ce),
    .ev_tdata_i     (data),
    .ev_valid_i     (valid),
    .ev_last_i      (last),
    .m_axis         (axis.master),
    .start_ok_o     (start_ok),
    .overflow_o     (ovf),
    .clr_err_i      (clr),
    .event_count_o  (ev_cnt),
    .length_err_o   (len_err),
    .dbg_fill_o     (fill),
    .dbg_in_event_o (in_ev_dbg)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the FIFO is a queue of {last, data}
  logic [8:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_in_ev = 1'b0;
  logic        m_start_ok = 1'b0;
  logic        m_len_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [15:0] m_wc = 16'd0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit          pop, req, is_full, acc, so_nx, len_bad;
    logic [15:0] n;
    started = 1'b1;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_in_ev = 1'b0;
      m_start_ok = 1'b0;
      m_cnt = 16'd0;
      m_wc = 16'd0;
      m_len_err = 1'b0;
    end else begin
      pop     = (m_q.size() != 0) && axis.tready;
      req     = valid && ce;
      is_full = (m_q.size() == DEPTH);
      acc     = req && (!is_full || pop);
      so_nx   = (m_q.size() <= THRESH) && !m_in_ev;
      if (pop) begin
        if (m_q[0][8]) m_cnt = m_cnt + 16'd1;
        void'(m_q.pop_front());
      end
      if (acc) m_q.push_back({last, data});
      if (req && is_full && !pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (acc) m_in_ev = !last;
      m_start_ok = so_nx;
`ifdef UEV_AXIS_LENCHECK_EN
      n = (m_wc == 16'hFFFF) ? m_wc : m_wc + 16'd1;
      len_bad = req && last && (int'(n) != EVENT_WORDS);
      if (req) m_wc = last ? 16'd0 : n;
      if (len_bad) m_len_err = 1'b1;
      else if (clr) m_len_err = 1'b0;
`else
      n = 16'd0;
      len_bad = 1'b0;
`endif
    end
  end

  // scoreboard compare + output beat monitor
  int         beats = 0;
  int         last_idx = 0;
  bit         saw_drop = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (started) begin
      chk("tvalid", axis.tvalid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("tdata", axis.tdata, m_q[0][7:0]);
        chk("tlast", axis.tlast, m_q[0][8]);
      end
      chk("fill", fill, m_q.size());
      chk("overflow", ovf, m_ovf);
      chk("start_ok", start_ok, m_start_ok);
      chk("event_count", ev_cnt, m_cnt);
      chk("in_event", in_ev_dbg, m_in_ev);
      chk("length_err", len_err, m_len_err);
      if (axis.tvalid && axis.tready && !rst) begin
        beats++;
        if (axis.tlast) last_idx = beats;
        if (axis.tdata == 8'hA5 || axis.tdata == 8'hA6) saw_drop = 1'b1;
        last_data = axis.tdata;
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [7:0] d, input logic l);
    @(posedge clk); #1;
    ce = 1'b1; valid = 1'b1; data = d; last = l;
    @(posedge clk); #1;
    ce = 1'b0; valid = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    axis.tready = 1'b0;
    idle(3);
    @(negedge clk);
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_start_ok", start_ok, 1'b0);
    chk("rst_overflow", ovf, 1'b0);
    chk("rst_event_count", ev_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    chk("start_ok_after_rst", start_ok, 1'b1);

    // ten-word event straight through
    axis.tready = 1'b1;
    beats = 0; last_idx = 0;
    for (int i = 0; i < 10; i++) push_word(8'(i + 16), i == 9);
    idle(5);
    @(negedge clk);
    chk("ev10_beats", beats, 10);
    chk("ev10_last_beat", last_idx, 10);
    chk("ev10_count", ev_cnt, 16'd1);

    // fill to 64, 65th word is dropped
    axis.tready = 1'b0;
    for (int i = 0; i < 64; i++) push_word(8'(i), i == 63);
    push_word(8'hA5, 1'b1);
    @(negedge clk);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_fill", fill, 7'd64);
    @(posedge clk); #1;
    clr = 1'b1; ce = 1'b1; valid = 1'b1; data = 8'hA6; last = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; ce = 1'b0; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    chk("ovf_beats_clr", ovf, 1'b1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 1'b0);

    // push while full with a pop in the same cycle
    @(posedge clk); #1;
    ce = 1'b1; valid = 1'b1; data = 8'h77; last = 1'b1; axis.tready = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0; valid = 1'b0; last = 1'b0; axis.tready = 1'b0;
    @(negedge clk);
    chk("full_pp_ovf", ovf, 1'b0);
    chk("full_pp_fill", fill, 7'd64);
    axis.tready = 1'b1;
    idle(80);
    @(negedge clk);
    chk("dropped_absent", saw_drop, 1'b0);
    chk("full_pp_tail", last_data, 8'h77);
    chk("drained_fill", fill, 7'd0);
    chk("count_after_full", ev_cnt, 16'd3);

    // start_ok threshold and mid-event gating
    axis.tready = 1'b0;
    for (int i = 0; i < 9; i++) push_word(8'(i + 32), i == 8);
    idle(2);
    @(negedge clk);
    chk("thr_fill9", fill, 7'd9);
    chk("thr_start_ok9", start_ok, 1'b0);
    @(posedge clk); #1;
    axis.tready = 1'b1;
    @(posedge clk); #1;
    axis.tready = 1'b0;
    @(negedge clk);
    chk("thr_fill8", fill, 7'd8);
    chk("thr_start_ok_lag", start_ok, 1'b0);
    @(negedge clk);
    chk("thr_start_ok8", start_ok, 1'b1);
    push_word(8'h51, 1'b0);
    idle(2);
    @(negedge clk);
    chk("mid_event_start_ok", start_ok, 1'b0);
    push_word(8'h52, 1'b1);
    axis.tready = 1'b1;
    idle(20);

    // reset in the middle of an event
    axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(i + 64), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", axis.tvalid, 1'b0);
    chk("rst_mid_fill", fill, 7'd0);
    axis.tready = 1'b1;
    beats = 0; last_idx = 0;
    for (int i = 0; i < 3; i++) push_word(8'(i + 80), i == 2);
    idle(6);
    @(negedge clk);
    chk("post_rst_beats", beats, 3);
    chk("post_rst_last_beat", last_idx, 3);
    chk("post_rst_count", ev_cnt, 16'd1);

    // randomized traffic: a flowing phase, then a congested phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        axis.tready = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        ce = ~ce;
        valid = ($urandom_range(0, 3) != 0);
        data = 8'($urandom_range(0, 255));
        last = ($urandom_range(0, 5) == 0);
        clr = ($urandom_range(0, 19) == 0);
      end
    end
    @(posedge clk); #1;
    ce = 1'b0; valid = 1'b0; last = 1'b0; clr = 1'b0;
    axis.tready = 1'b1;
    idle(140);

`ifdef UEV_AXIS_LENCHECK_EN
    // close any open event, clear, then send one word short of a full event
    push_word(8'h00, 1'b1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("len_err_pre_clear", len_err, 1'b0);
    for (int i = 0; i < EVENT_WORDS - 1; i++) push_word(8'(i), i == EVENT_WORDS - 2);
    idle(2);
    @(negedge clk);
    chk("len_err_short", len_err, 1'b1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("len_err_cleared", len_err, 1'b0);
    idle(4);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
